tile_ram_arbiter: RTL and testbench
===================================

# tile_ram_arbiter

Shares one port of a tile RAM (`tile_RAM_US`-style BRAM, 1-cycle or 2-cycle read latency) between three requesters:
- a video read stream from the screen controller;
- PicoBlaze-interface tile writes;
- PicoBlaze-interface tile reads (cursor lookups).

Video has priority, with a starvation guard for the PicoBlaze side. Returning read data is routed back to the requester that issued the read. The block sits between `nexys4_pico_if`/`dynamic_screen` and the RAM, and replaces the direct write/cursor address mux.

## Interface
Parameters:
- ADDR_W, 10, RAM address width
- DATA_W, 4, RAM data width
- RD_LAT, 1, RAM read latency in clocks (legal 1 or 2)
- STARVE_LIMIT, 8, consecutive denied cycles before a PicoBlaze request overrides video (1..255)

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-low reset
- vid_req  in  1  single-cycle video read request
- vid_addr  in  ADDR_W  video read address, sampled with vid_req
- vid_valid  out  1  one-cycle pulse, vid_data valid
- vid_data  out  DATA_W  video read data
- wr_req  in  1  write request, level; hold until wr_ack
- wr_addr  in  ADDR_W  write address, stable while wr_req
- wr_data  in  DATA_W  write data, stable while wr_req
- wr_ack  out  1  combinational grant for the write, same cycle
- rd_req  in  1  read request, level; hold until rd_ack
- rd_addr  in  ADDR_W  read address, stable while rd_req
- rd_ack  out  1  combinational grant for the read, same cycle
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  DATA_W  read data
- ram_en  out  1  RAM port enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data

## Operation
- Exactly one grant per cycle. Candidates are PEND (pending video), VID (new vid_req), WR and RD.
- Priority order:
  - PEND first.
  - Then any starved PicoBlaze requester (wait counter == STARVE_LIMIT).
  - Then VID.
  - Then WR/RD in round-robin.
- Round-robin pointer: after reset it points to WR. After any WR or RD grant it points to the other requester. Two starved requesters are resolved by the same pointer.
- Pending video register, one entry:
  - If vid_req arrives in a cycle where VID is not granted (PEND or a starved requester wins), vid_addr is captured into PEND.
  - PEND always wins the following cycle, so it can never overflow.
  - Video order is preserved; no video request is ever dropped.
- Wait counters, one each for WR and RD, 8 bits:
  - Increment each cycle the request is high and not granted.
  - Clear on grant, or when the request is low.
  - Saturate at STARVE_LIMIT.
- Withdrawal: dropping wr_req/rd_req before ack is legal. No access is issued and the counter clears.
- Back-to-back: a request still high at the edge after its ack is a new request.
- Tag pipeline: RD_LAT+1 stages of {valid, owner}, owner ∈ {VID, RD}. ram_dout is registered into vid_data or rd_data according to the tag.
- Writes never produce a data return.
- Idle cycle: ram_en=0, ram_we=0, ram_addr and ram_din hold their last value.

## Timing
- Reset (async assert): every output is 0, including vid_data and rd_data. PEND, tags, counters and the RR pointer are cleared.
  - In-flight reads produce no valid pulse.
  - A captured PEND entry is discarded.
- Grant cycle N: wr_ack/rd_ack are combinational in cycle N. ram_en/ram_we/ram_addr/ram_din are registered and driven in cycle N+1.
- Read return: vid_valid/rd_valid assert in cycle N+RD_LAT+2, i.e. N+3 for RD_LAT=1.
  - A video request delayed into PEND returns one cycle later than it would have.
- Write: RAM is written at the end of cycle N+1. A read granted in cycle N+1 or later at the same address returns the new data.
- Throughput: one access per cycle sustained.

## Test plan
- Reset: hold reset=0 with random inputs → all outputs 0. Release → first vid_req at cycle 0, addr 0x005, RAM[0x005]=0x3, RD_LAT=1 → vid_valid=1 and vid_data=0x3 in cycle 3 only.
- Round-robin: wr_req and rd_req both held, no video, wr_addr 0x010/wr_data 0xA, rd_addr 0x010:
  - wr_ack in cycle 0, rd_ack in cycle 1, alternating thereafter;
  - first rd_data = 0xA.
- Starvation: vid_req every cycle and wr_req raised at cycle 0:
  - wr_ack in cycle 8;
  - video from cycle 8 returns in cycle 12, not 11;
  - all video returns stay in order, none lost.
- Withdrawal: rd_req high for cycles 0–2 while video wins, dropped before grant → no rd_ack, no rd_valid, ram_en never carries rd_addr.
- Reset mid-read: rd_ack in cycle 0, reset asserted in cycle 1 → no rd_valid; all outputs 0 until reset is released.
- RD_LAT=2 build: single rd_req granted in cycle 0 → rd_valid in cycle 4.

Source files
------------

// File: rtl/tile_ram_arbiter.sv
// Arbitrates one tile-RAM port between video reads, PicoBlaze writes and PicoBlaze reads.
// Video wins by default; a PicoBlaze requester denied STARVE_LIMIT cycles overrides it.
module tile_ram_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 4,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [2:0] G_NONE = 3'd0;
    localparam logic [2:0] G_PEND = 3'd1;
    localparam logic [2:0] G_VID  = 3'd2;
    localparam logic [2:0] G_WR   = 3'd3;
    localparam logic [2:0] G_RD   = 3'd4;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [2:0]        grant;
    logic [ADDR_W-1:0] acc_addr;
    logic              pend_vld;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        wr_wait;
    logic [7:0]        rd_wait;
    logic              rr_rd;
    logic              wr_starve;
    logic              rd_starve;
    logic              issue_rd;
    logic              issue_vid;
    logic [RD_LAT:0]   tag_vld;
    logic [RD_LAT:0]   tag_vid;

    assign wr_starve = wr_req && (wr_wait == LIMIT);
    assign rd_starve = rd_req && (rd_wait == LIMIT);

    // A held pending video always wins next, so the single PEND slot cannot overflow.
    always_comb begin
        grant = G_NONE;
        if (pend_vld)
            grant = G_PEND;
        else if (wr_starve && rd_starve)
            grant = rr_rd ? G_RD : G_WR;
        else if (wr_starve)
            grant = G_WR;
        else if (rd_starve)
            grant = G_RD;
        else if (vid_req)
            grant = G_VID;
        else if (wr_req && rd_req)
            grant = rr_rd ? G_RD : G_WR;
        else if (wr_req)
            grant = G_WR;
        else if (rd_req)
            grant = G_RD;
    end

    always_comb begin
        acc_addr = vid_addr;
        case (grant)
            G_PEND:  acc_addr = pend_addr;
            G_WR:    acc_addr = wr_addr;
            G_RD:    acc_addr = rd_addr;
            default: acc_addr = vid_addr;
        endcase
    end

    // Acks are gated by reset so every output reads 0 while reset is held.
    assign wr_ack = reset && (grant == G_WR);
    assign rd_ack = reset && (grant == G_RD);

    assign issue_vid = (grant == G_PEND) || (grant == G_VID);
    assign issue_rd  = issue_vid || (grant == G_RD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            wr_wait   <= '0;
            rd_wait   <= '0;
            rr_rd     <= 1'b0;
        end else begin
            pend_vld <= vid_req && (grant != G_VID);
            if (vid_req && (grant != G_VID))
                pend_addr <= vid_addr;

            if (!wr_req || (grant == G_WR))
                wr_wait <= '0;
            else if (wr_wait < LIMIT)
                wr_wait <= wr_wait + 8'd1;

            if (!rd_req || (grant == G_RD))
                rd_wait <= '0;
            else if (rd_wait < LIMIT)
                rd_wait <= rd_wait + 8'd1;

            if (grant == G_WR)
                rr_rd <= 1'b1;
            else if (grant == G_RD)
                rr_rd <= 1'b0;
        end
    end

    // RAM port is registered; address and data hold through idle cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_en <= (grant != G_NONE);
            ram_we <= (grant == G_WR);
            if (grant != G_NONE)
                ram_addr <= acc_addr;
            if (grant == G_WR)
                ram_din <= wr_data;
        end
    end

    // Tag stage k lines up with the RAM access in cycle N+1+k; stage RD_LAT meets ram_dout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld <= '0;
            tag_vid <= '0;
        end else begin
            tag_vld <= {tag_vld[RD_LAT-1:0], issue_rd};
            tag_vid <= {tag_vid[RD_LAT-1:0], issue_vid};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vid_valid <= 1'b0;
            vid_data  <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            vid_valid <= tag_vld[RD_LAT] && tag_vid[RD_LAT];
            rd_valid  <= tag_vld[RD_LAT] && !tag_vid[RD_LAT];
            if (tag_vld[RD_LAT] && tag_vid[RD_LAT])
                vid_data <= ram_dout;
            if (tag_vld[RD_LAT] && !tag_vid[RD_LAT])
                rd_data <= ram_dout;
        end
    end

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Bench for tile_ram_arbiter: directed scenarios plus a randomized run against a cycle model.
// A second instance built with RD_LAT=2 shares all inputs.
module tb_tile_ram_arbiter;
    localparam int AW  = 10;
    localparam int DW  = 4;
    localparam int LIM = 8;
    localparam int GN = 0, GP = 1, GV = 2, GW = 3, GR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          vid_req, wr_req, rd_req;
    logic [AW-1:0] vid_addr, wr_addr, rd_addr;
    logic [DW-1:0] wr_data;

    logic          vid_valid1, wr_ack1, rd_ack1, rd_valid1, ram_en1, ram_we1;
    logic [DW-1:0] vid_data1, rd_data1, ram_din1, ram_dout1;
    logic [AW-1:0] ram_addr1;
    logic          vid_valid2, wr_ack2, rd_ack2, rd_valid2, ram_en2, ram_we2;
    logic [DW-1:0] vid_data2, rd_data2, ram_din2, ram_dout2;
    logic [AW-1:0] ram_addr2;

    int checks = 0;
    int errors = 0;

    tile_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid1), .vid_data(vid_data1),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack1),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack1), .rd_valid(rd_valid1), .rd_data(rd_data1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_dout(ram_dout1)
    );

    tile_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .STARVE_LIMIT(LIM)) dut2 (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid2), .vid_data(vid_data2),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack2),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack2), .rd_valid(rd_valid2), .rd_data(rd_data2),
        .ram_en(ram_en2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_din(ram_din2), .ram_dout(ram_dout2)
    );

    function automatic logic [DW-1:0] hash(int i);
        return DW'((3 * i + 4) & 15);
    endfunction

    // BRAM models; contents reload to hash(addr) whenever reset is low at a clock edge.
    logic [DW-1:0] mem1 [1024];
    logic [DW-1:0] mem2 [1024];
    logic [DW-1:0] dout1 = '0, dout2a = '0, dout2b = '0;
    assign ram_dout1 = dout1;
    assign ram_dout2 = dout2b;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= hash(i);
        end else if (ram_en1) begin
            if (ram_we1) mem1[ram_addr1] <= ram_din1;
            else         dout1 <= mem1[ram_addr1];
        end
    end

    always @(posedge clk) begin
        dout2b <= dout2a;
        if (!reset) begin
            for (int i = 0; i < 1024; i++) mem2[i] <= hash(i);
        end else if (ram_en2) begin
            if (ram_we2) mem2[ram_addr2] <= ram_din2;
            else         dout2a <= mem2[ram_addr2];
        end
    end

    function automatic logic [27:0] outs1();
        return {wr_ack1, rd_ack1, vid_valid1, vid_data1, rd_valid1, rd_data1, ram_en1, ram_we1, ram_addr1, ram_din1};
    endfunction

    function automatic logic [27:0] outs2();
        return {wr_ack2, rd_ack2, vid_valid2, vid_data2, rd_valid2, rd_data2, ram_en2, ram_we2, ram_addr2, ram_din2};
    endfunction

    task automatic zero_inputs();
        vid_req = 0; vid_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0; rd_req = 0; rd_addr = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        zero_inputs();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vid_req = 1'($urandom); wr_req = 1'($urandom); rd_req = 1'($urandom);
            vid_addr = AW'($urandom); wr_addr = AW'($urandom); rd_addr = AW'($urandom); wr_data = DW'($urandom);
            @(negedge clk);
            checks++;
            if (outs1() !== 28'd0) begin errors++; $display("FAIL reset_outs c=%0d got %h exp 0", c, outs1()); end
            checks++;
            if (outs2() !== 28'd0) begin errors++; $display("FAIL reset_outs_lat2 c=%0d got %h exp 0", c, outs2()); end
        end
        zero_inputs();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            vid_req = (c == 0); vid_addr = AW'(5);
            @(negedge clk);
            checks++;
            if (vid_valid1 !== (c == 3)) begin errors++; $display("FAIL first_vid_valid c=%0d got %b exp %b", c, vid_valid1, c == 3); end
            if (c == 3) begin
                checks++;
                if (vid_data1 !== 4'h3) begin errors++; $display("FAIL first_vid_data got %h exp 3", vid_data1); end
            end
        end
    endtask

    task automatic test_round_robin();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            wr_req = (c <= 5); wr_addr = AW'('h010); wr_data = 4'hA;
            rd_req = (c <= 5); rd_addr = AW'('h010); vid_req = 0;
            @(negedge clk);
            checks++;
            if (wr_ack1 !== (c <= 5 && c % 2 == 0)) begin errors++; $display("FAIL rr_wr_ack c=%0d got %b", c, wr_ack1); end
            checks++;
            if (rd_ack1 !== (c <= 5 && c % 2 == 1)) begin errors++; $display("FAIL rr_rd_ack c=%0d got %b", c, rd_ack1); end
            checks++;
            if (rd_valid1 !== (c == 4 || c == 6 || c == 8)) begin errors++; $display("FAIL rr_rd_valid c=%0d got %b", c, rd_valid1); end
            if (c == 4) begin
                checks++;
                if (rd_data1 !== 4'hA) begin errors++; $display("FAIL rr_rd_data got %h exp a", rd_data1); end
            end
        end
    endtask

    task automatic test_starvation();
        int nret = 0;
        int k;
        for (int c = 0; c < 18; c++) begin
            @(posedge clk); #1;
            vid_req = (c < 12); vid_addr = AW'(256 + c);
            wr_req = (c <= 8); wr_addr = AW'('h020); wr_data = 4'h5; rd_req = 0;
            @(negedge clk);
            checks++;
            if (wr_ack1 !== (c == 8)) begin errors++; $display("FAIL starve_wr_ack c=%0d got %b exp %b", c, wr_ack1, c == 8); end
            // Requests 0..7 return after 3 cycles; from the starved grant on, after 4.
            k = -1;
            if (c >= 3 && c <= 10) k = c - 3;
            else if (c >= 12 && c <= 15) k = c - 4;
            checks++;
            if (vid_valid1 !== (k >= 0)) begin errors++; $display("FAIL starve_vid_valid c=%0d got %b exp %b", c, vid_valid1, k >= 0); end
            if (vid_valid1) nret++;
            if (k >= 0) begin
                checks++;
                if (vid_data1 !== hash(256 + k)) begin errors++; $display("FAIL starve_vid_data c=%0d got %h exp %h", c, vid_data1, hash(256 + k)); end
            end
        end
        checks++;
        if (nret != 12) begin errors++; $display("FAIL starve_vid_count got %0d exp 12", nret); end
    endtask

    task automatic test_withdrawal();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            vid_req = (c <= 4); vid_addr = AW'('h200 + c);
            rd_req = (c <= 2); rd_addr = AW'('h3C3); wr_req = 0;
            @(negedge clk);
            checks++;
            if ({rd_ack1, rd_valid1} !== 2'b00) begin errors++; $display("FAIL withdraw_rd c=%0d got ack %b valid %b exp 0", c, rd_ack1, rd_valid1); end
            checks++;
            if (ram_en1 && !ram_we1 && ram_addr1 == AW'('h3C3)) begin errors++; $display("FAIL withdraw_ram_addr c=%0d got %h", c, ram_addr1); end
        end
    endtask

    task automatic test_reset_mid_read();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            rd_req = (c == 0); rd_addr = AW'(7); vid_req = 0; wr_req = 0;
            if (c == 1) reset = 1'b0;
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (rd_ack1 !== 1'b1) begin errors++; $display("FAIL midrd_ack got %b exp 1", rd_ack1); end
            end else if (c <= 5) begin
                checks++;
                if (outs1() !== 28'd0) begin errors++; $display("FAIL midrd_outs c=%0d got %h exp 0", c, outs1()); end
                checks++;
                if (outs2() !== 28'd0) begin errors++; $display("FAIL midrd_outs_lat2 c=%0d got %h exp 0", c, outs2()); end
            end else begin
                checks++;
                if ({rd_valid1, rd_valid2} !== 2'b00) begin errors++; $display("FAIL midrd_valid c=%0d got %b%b exp 00", c, rd_valid1, rd_valid2); end
            end
            if (c == 5) reset = 1'b1;
        end
    endtask

    task automatic test_rd_lat2();
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            rd_req = (c == 0); rd_addr = AW'(9);
            @(negedge clk);
            checks++;
            if ({rd_ack1, rd_ack2, wr_ack2} !== {c == 0, c == 0, 1'b0}) begin errors++; $display("FAIL lat2_ack c=%0d got %b%b%b", c, rd_ack1, rd_ack2, wr_ack2); end
            checks++;
            if ({rd_valid1, rd_valid2} !== {c == 3, c == 4}) begin errors++; $display("FAIL lat2_valid c=%0d got %b%b", c, rd_valid1, rd_valid2); end
            if (c == 4) begin
                checks++;
                if (rd_data2 !== hash(9)) begin errors++; $display("FAIL lat2_data got %h exp %h", rd_data2, hash(9)); end
            end
        end
    endtask

    task automatic test_random();
        int pend_q[$];
        int wt_w, wt_r, g, pg, acc, pacc;
        bit next_wr, sw, sr;
        logic [DW-1:0] pdin, d;
        logic [DW-1:0] sh [1024];
        bit evv[700], erv[700], evv2[700], erv2[700];
        logic [DW-1:0] evd[700], erd[700], evd2[700], erd2[700];

        @(posedge clk); #1;
        zero_inputs();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) sh[i] = hash(i);
        for (int i = 0; i < 700; i++) begin
            evv[i] = 0; erv[i] = 0; evv2[i] = 0; erv2[i] = 0;
            evd[i] = '0; erd[i] = '0; evd2[i] = '0; erd2[i] = '0;
        end
        wt_w = 0; wt_r = 0; next_wr = 1; pg = GN; pacc = 0; pdin = '0;

        for (int c = 0; c < 620; c++) begin
            @(posedge clk); #1;
            if (c < 600) begin
                vid_req = ($urandom_range(0, 99) < 70);
                vid_addr = AW'($urandom_range(0, 15));
                if (wr_req && pg != GW) begin
                    if ($urandom_range(0, 19) == 0) wr_req = 0;
                end else begin
                    wr_req = ($urandom_range(0, 99) < 45);
                    wr_addr = AW'($urandom_range(0, 15)); wr_data = DW'($urandom);
                end
                if (rd_req && pg != GR) begin
                    if ($urandom_range(0, 19) == 0) rd_req = 0;
                end else begin
                    rd_req = ($urandom_range(0, 99) < 45);
                    rd_addr = AW'($urandom_range(0, 15));
                end
            end else begin
                zero_inputs();
            end
            @(negedge clk);

            sw = wr_req && wt_w == LIM;
            sr = rd_req && wt_r == LIM;
            if (pend_q.size() != 0)        g = GP;
            else if (sw && sr)             g = next_wr ? GW : GR;
            else if (sw)                   g = GW;
            else if (sr)                   g = GR;
            else if (vid_req)              g = GV;
            else if (wr_req && rd_req)     g = next_wr ? GW : GR;
            else if (wr_req)               g = GW;
            else if (rd_req)               g = GR;
            else                           g = GN;
            acc = (g == GP) ? pend_q[0] : (g == GV) ? int'(vid_addr) : (g == GW) ? int'(wr_addr) : (g == GR) ? int'(rd_addr) : 0;

            checks++;
            if ({wr_ack1, rd_ack1} !== {g == GW, g == GR}) begin errors++; $display("FAIL rnd_ack c=%0d got %b%b exp %b%b", c, wr_ack1, rd_ack1, g == GW, g == GR); end
            checks++;
            if (ram_en1 !== (pg != GN)) begin errors++; $display("FAIL rnd_ram_en c=%0d got %b exp %b", c, ram_en1, pg != GN); end
            if (pg != GN) begin
                checks++;
                if ({ram_we1, ram_addr1} !== {pg == GW, AW'(pacc)}) begin errors++; $display("FAIL rnd_ram_port c=%0d got %b/%h exp %b/%h", c, ram_we1, ram_addr1, pg == GW, pacc); end
                if (pg == GW) begin
                    checks++;
                    if (ram_din1 !== pdin) begin errors++; $display("FAIL rnd_ram_din c=%0d got %h exp %h", c, ram_din1, pdin); end
                end
            end
            checks++;
            if ({vid_valid1, rd_valid1, vid_valid2, rd_valid2} !== {evv[c], erv[c], evv2[c], erv2[c]}) begin
                errors++;
                $display("FAIL rnd_valid c=%0d got %b%b%b%b exp %b%b%b%b", c, vid_valid1, rd_valid1, vid_valid2, rd_valid2, evv[c], erv[c], evv2[c], erv2[c]);
            end
            if (evv[c]) begin checks++; if (vid_data1 !== evd[c]) begin errors++; $display("FAIL rnd_vid_data c=%0d got %h exp %h", c, vid_data1, evd[c]); end end
            if (erv[c]) begin checks++; if (rd_data1 !== erd[c]) begin errors++; $display("FAIL rnd_rd_data c=%0d got %h exp %h", c, rd_data1, erd[c]); end end
            if (evv2[c]) begin checks++; if (vid_data2 !== evd2[c]) begin errors++; $display("FAIL rnd_vid_data_lat2 c=%0d got %h exp %h", c, vid_data2, evd2[c]); end end
            if (erv2[c]) begin checks++; if (rd_data2 !== erd2[c]) begin errors++; $display("FAIL rnd_rd_data_lat2 c=%0d got %h exp %h", c, rd_data2, erd2[c]); end end

            // Writes land in the shadow at grant time; later-granted reads see them.
            if (g == GP || g == GV || g == GR) begin
                d = sh[acc];
                if (g == GR) begin erv[c+3] = 1; erd[c+3] = d; erv2[c+4] = 1; erd2[c+4] = d; end
                else         begin evv[c+3] = 1; evd[c+3] = d; evv2[c+4] = 1; evd2[c+4] = d; end
            end
            if (g == GW) sh[acc] = wr_data;

            if (g == GP) void'(pend_q.pop_front());
            if (vid_req && g != GV) pend_q.push_back(int'(vid_addr));
            wt_w = (!wr_req || g == GW) ? 0 : (wt_w < LIM ? wt_w + 1 : wt_w);
            wt_r = (!rd_req || g == GR) ? 0 : (wt_r < LIM ? wt_r + 1 : wt_r);
            if (g == GW) next_wr = 0;
            if (g == GR) next_wr = 1;
            pg = g; pacc = acc; pdin = wr_data;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_starvation();
        test_withdrawal();
        test_reset_mid_read();
        test_rd_lat2();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
